// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and frame geometry.
package uart_pkg;
    localparam int UART_OSR       = 6;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with wrap-bit pointers; read data valid whenever not empty.
// Latency: write visible on rdata the cycle after push when previously empty.
// Backpressure: push ignored while full; simultaneous push and pop both honoured.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Equal index with differing wrap bit means the writer has lapped the reader.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter timed by an external OSR-times-baud enable, fed by a small FIFO.
// Latency: start bit drives the line one clk after the first uart_clk pulse that sees data queued.
// Backpressure: tx_ready is the registered FIFO not-full flag; producer holds tx_valid until taken.
module uart_tx
    import uart_pkg::*;
#(
    parameter int OSR   = UART_OSR,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_clk,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);
    localparam int TW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OSR - 1);
    localparam logic [TW-1:0] TICK_ONE  = 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = 1;

    uart_state_e      state_q, state_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             fifo_pop, fifo_full, fifo_empty, tick_last;
    logic [7:0]       fifo_rdata;

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tx_valid && tx_ready),
        .pop     (fifo_pop),
        .wdata   (tx_data),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tx_ready  = !fifo_full;
    assign tx        = tx_q;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign tick_last = (tick_q == TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Every transition happens on a uart_clk pulse; the level set there holds for OSR further pulses.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        if (uart_clk) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        tick_d   = '0;
                        bit_d    = '0;
                        tx_d     = 1'b0;
                        state_d  = ST_START;
                    end
                end
                ST_START: begin
                    if (tick_last) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        tx_d    = shift_q[0];
                        state_d = ST_DATA;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                ST_DATA: begin
                    if (tick_last) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BIT_ONE;
                        if (bit_q == BIT_LAST) begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end else begin
                            tx_d = shift_q[1];
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                ST_STOP: begin
                    if (tick_last) begin
                        tick_d = '0;
                        bit_d  = '0;
                        // Back-to-back frames: the stop bit's last tick launches the next start bit.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_rdata;
                            tx_d     = 1'b0;
                            state_d  = ST_START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: decodes the serial line in uart_clk pulses and checks bytes and timing.
module tb_uart_tx;
    localparam int OSR_TB = 6;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       uart_clk;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int uc_mode = 0;
    int gap = 0;
    int idle_cyc = 0;

    bit         in_frame = 1'b0;
    int         p0, cur_bit, fr_cyc, dec_b;
    logic [9:0] fr;
    bit         glitch;
    logic [7:0] rx_q[$];
    bit         rx_bad_q[$];
    int         rx_p0_q[$];
    int         rx_cyc_q[$];

    logic [7:0] batch[5];
    logic [7:0] irr[4];
    int base, n, start_p;
    bit low_seen;

    uart_tx #(.OSR(6), .DEPTH(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .uart_clk (uart_clk),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Mode 0: no pulses; mode 1: every 31 clk; mode 2: random spacing 1..100 clk.
    initial begin
        uart_clk = 1'b0;
        forever begin
            @(negedge clk);
            if (uc_mode == 0) begin
                uart_clk = 1'b0;
                gap = 0;
            end else if (gap == 0) begin
                uart_clk = 1'b1;
                gap = (uc_mode == 1) ? 30 : $urandom_range(0, 99);
            end else begin
                uart_clk = 1'b0;
                gap--;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (uart_clk === 1'b1) pulse_cnt++;
        end
    end

    task automatic dec_start();
        in_frame = 1'b1;
        p0       = pulse_cnt;
        cur_bit  = 0;
        fr       = '0;
        fr[0]    = tx;
        glitch   = 1'b0;
        fr_cyc   = cyc;
    endtask

    // Line decoder: bit k spans pulses [6k, 6k+5] after the start edge; any level change inside a bit is a glitch.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (tx === 1'b0) dec_start();
            end else begin
                dec_b = (pulse_cnt - p0) / OSR_TB;
                if (dec_b >= 10) begin
                    rx_q.push_back(fr[8:1]);
                    rx_bad_q.push_back(glitch || fr[0] || !fr[9]);
                    rx_p0_q.push_back(p0);
                    rx_cyc_q.push_back(fr_cyc);
                    in_frame = 1'b0;
                    if (tx === 1'b0) dec_start();
                end else if (dec_b != cur_bit) begin
                    cur_bit    = dec_b;
                    fr[dec_b]  = tx;
                end else if (tx !== fr[cur_bit]) begin
                    glitch = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        int k = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("push accepted", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        idle_cyc = cyc;
        chk({tag, " idle"}, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        batch    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5E};
        irr      = '{8'h00, 8'hFF, 8'h3C, 8'h81};
        repeat (3) @(negedge clk);
        chk("reset tx", tx, 1);
        chk("reset tx_ready", tx_ready, 1);
        chk("reset busy", busy, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single 0x55 frame at regular 31-clk pulse spacing
        uc_mode = 1;
        base = rx_q.size();
        push(8'h55);
        chk("t1 busy after push", busy, 1);
        wait_idle(3000, "t1");
        chk("t1 frame count", rx_q.size(), base + 1);
        if (rx_q.size() > base) begin
            chk("t1 byte", rx_q[base], 8'h55);
            chk("t1 framing", rx_bad_q[base], 0);
            chk("t1 start-to-idle clk", idle_cyc - rx_cyc_q[base], 1860);
        end
        chk("t1 line idle", tx, 1);

        // 0xA3: data bits 1,1,0,0,0,1,0,1 then six-tick stop
        base = rx_q.size();
        push(8'hA3);
        wait_idle(3000, "t2");
        chk("t2 frame count", rx_q.size(), base + 1);
        if (rx_q.size() > base) begin
            chk("t2 byte", rx_q[base], 8'hA3);
            chk("t2 framing", rx_bad_q[base], 0);
        end

        // Fill FIFO with uart_clk frozen, hold a fifth byte, then release the enable
        uc_mode = 0;
        repeat (2) @(negedge clk);
        base = rx_q.size();
        for (int i = 0; i < 4; i++) push(batch[i]);
        chk("t3 full ready", tx_ready, 0);
        tx_data  = batch[4];
        tx_valid = 1'b1;
        repeat (10) @(negedge clk);
        chk("t3 held ready", tx_ready, 0);
        chk("t3 frozen tx", tx, 1);
        chk("t3 busy", busy, 1);
        uc_mode = 1;
        n = 0;
        while (tx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t3 fifth accepted", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle(5 * 1860 + 500, "t3");
        chk("t3 frame count", rx_q.size(), base + 5);
        if (rx_q.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("t3 byte", rx_q[base + i], batch[i]);
                chk("t3 framing", rx_bad_q[base + i], 0);
                if (i > 0) chk("t3 frame spacing pulses", rx_p0_q[base + i] - rx_p0_q[base + i - 1], 60);
            end
        end

        // Reset during data bit 3
        push(8'hC6);
        n = 0;
        while (!(in_frame && cur_bit == 3) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("t4 reached bit 3", cur_bit, 3);
        base = rx_q.size();
        reset_n = 1'b0;
        #1;
        chk("t4 reset tx", tx, 1);
        chk("t4 reset busy", busy, 0);
        chk("t4 reset tx_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        reset_n  = 1'b1;
        start_p  = pulse_cnt;
        low_seen = 1'b0;
        n = 0;
        while (pulse_cnt < start_p + 200 && n < 200 * 31 + 200) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
            n++;
        end
        chk("t4 200 pulses elapsed", pulse_cnt >= start_p + 200, 1);
        chk("t4 line stayed high", low_seen, 0);
        chk("t4 no retransmit", rx_q.size(), base);
        chk("t4 busy after release", busy, 0);

        // Irregular uart_clk spacing
        uc_mode = 2;
        base = rx_q.size();
        for (int i = 0; i < 4; i++) push(irr[i]);
        wait_idle(4 * 60 * 101 + 500, "t5");
        chk("t5 frame count", rx_q.size(), base + 4);
        if (rx_q.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t5 byte", rx_q[base + i], irr[i]);
                chk("t5 framing", rx_bad_q[base + i], 0);
                if (i > 0) chk("t5 frame spacing pulses", rx_p0_q[base + i] - rx_p0_q[base + i - 1], 60);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that pairs with the system block's RX path. It sends 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) on `tx`. Bit timing comes from the existing `uart_clk` enable, which pulses at 6x the baud rate, so no divider is duplicated here. A small FIFO decouples the byte producer (debug and status logic) from line timing.

## Interface

Parameters:
- `OSR`, 6, `uart_clk` pulses per serial bit; must match the system block's 6x rate.
- `DEPTH`, 4, FIFO entries; power of two, minimum 2.

Ports:
- `clk`  input  1  system clock. One clock; every register is on its rising edge.
- `reset_n`  input  1  reset, asynchronous and active-low.
- `uart_clk`  input  1  one-`clk`-wide enable pulse at 6x baud.
- `tx_data`  input  8  byte to send.
- `tx_valid`  input  1  producer offers `tx_data`.
- `tx_ready`  output  1  FIFO can accept a byte; high when not full.
- `tx`  output  1  serial line, idle high, registered.
- `busy`  output  1  high when a frame is in progress or the FIFO is non-empty.

## Operation

- Accept: a byte is written when `tx_valid && tx_ready` at a `clk` edge. The producer holds `tx_data`/`tx_valid` until accepted.
- FIFO:
  - Pointers are log2(DEPTH)+1 bits, so full and empty are distinguished by the wrap bit.
  - Full: `tx_ready`=0, and writes are ignored.
  - A pop and a push in the same cycle are both honoured.
- States: IDLE, START, DATA, STOP.
- Counters:
  - tick counter, 0..OSR-1, advances only on `uart_clk`;
  - bit index, 0..7;
  - shift register, 8 bits.
- IDLE: `tx`=1.
  - On a `uart_clk` pulse with FIFO non-empty: pop the head into the shift register, clear the tick counter, and go to START.
  - Without a pulse, stay in IDLE even if data is waiting.
- START: `tx`=0 for OSR ticks, then go to DATA with bit index 0.
- DATA: `tx`=shift[0] for OSR ticks, then shift right and increment the bit index. After bit 7 completes, go to STOP.
- STOP: `tx`=1 for OSR ticks.
  - At the end, if the FIFO is non-empty, pop and go directly to START; no idle gap between frames.
  - Otherwise go to IDLE.
- `uart_clk` with no `clk` activity in between is impossible; `uart_clk` held low freezes the state machine indefinitely with `tx` stable.
- Reset, asserted at any time including mid-frame:
  - outputs: `tx`=1, `tx_ready`=1, `busy`=0;
  - internal: state IDLE, FIFO emptied, all counters 0.
  - A partially sent frame is abandoned; no byte is retransmitted after release.

## Timing

- `tx` is registered and changes on the `clk` edge that samples the `uart_clk` pulse; it becomes visible the next cycle.
- Each bit lasts exactly OSR `uart_clk` pulses. A frame is 10×OSR = 60 pulses. With the default divisor of 31 clk per pulse, that is 186 clk per bit and 1860 clk per frame.
- Latency from accept to the start-bit edge is at most one `uart_clk` period plus 1 clk, when IDLE and the FIFO was empty.
- `tx_ready` reflects registered FIFO state only; it has no combinational path from `tx_valid`. It rises the cycle after a pop from full.
- `busy` falls the cycle after the final stop tick when the FIFO is empty.

## Structure

- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP);
  - `UART_OSR`=6;
  - `UART_DATA_BITS`=8.
- Sub-module `tx_fifo`: a synchronous FIFO parameterised by width and DEPTH, with ports `push`, `pop`, `wdata`, `rdata`, `full`, `empty`. Its read data is valid whenever `empty`=0.
- The top level holds the state machine, counters and shift register.

## Test plan

- Single byte 0x55, `uart_clk` every 31 clk → `tx` sequence is 0,1,0,1,0,1,0,1,0,1, each level exactly 186 clk, then idle high; `busy` falls after 1860 clk.
- Byte 0xA3 → data bits on the line are 1,1,0,0,0,1,0,1 (LSB first); stop bit high for 6 ticks.
- Hold `uart_clk`=0 and offer 5 bytes back-to-back → 4 accepted, `tx_ready`=0 while the 5th is held. Then enable `uart_clk` → the 5th byte is accepted after the first pop, and all 5 frames go out in order.
- Two bytes queued → second start bit begins exactly 60 ticks after the first, with no extra idle tick between frames.
- Assert `reset_n`=0 during DATA bit 3 → `tx`=1 immediately, `busy`=0, `tx_ready`=1. After release with no new pushes, `tx` stays high for 200 ticks.
- Irregular `uart_clk` spacing (gaps of 1 to 100 clk) → every bit still spans exactly 6 pulses and the decoded bytes match the pushed bytes.
